// File: rtl/csm_pkg.sv
// Shared definitions for the sequential carry-save multiplier: FSM state encoding
// and the default operand width.
package csm_pkg;

    localparam int WIDTH_DEF = 25;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/csm_row.sv
// One reusable row of full adders; the controller time-multiplexes it between
// partial-product accumulation and final carry propagation.
module full_adder_1b (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);
    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);
endmodule

module csm_row #(
    parameter int WIDTH = 25
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c
);
    for (genvar j = 0; j < WIDTH; j++) begin : g_fa
        full_adder_1b u_fa (
            .x (x[j]),
            .y (y[j]),
            .z (z[j]),
            .s (s[j]),
            .c (c[j])
        );
    end
endmodule

// File: rtl/csm_seq_mult_ctrl.sv
// Sequential carry-save multiplier: WIDTH cycles of shift-accumulate through one
// adder row, then ripple the leftover carry vector through the same row.
module csm_seq_mult_ctrl
    import csm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, s_q, c_q, plo_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] row_x, row_s, row_c;

    // Row sees the current partial product while accumulating, zeros while resolving.
    assign row_x = (state == ACCUM) ? (a_r & {WIDTH{b_r[0]}}) : '0;

    csm_row #(.WIDTH(WIDTH)) u_row (
        .x (row_x),
        .y (s_q),
        .z (c_q),
        .s (row_s),
        .c (row_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)                    state_nx = ACCUM;
            ACCUM:   if (cnt == CW'(WIDTH - 1))       state_nx = RESOLVE;
            RESOLVE: if (c_q == '0)                   state_nx = DONE;
            DONE:    if (out_ready)                   state_nx = IDLE;
            default:                                  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            s_q     <= '0;
            c_q     <= '0;
            plo_q   <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= a;
                    b_r   <= b;
                    s_q   <= '0;
                    c_q   <= '0;
                    plo_q <= '0;
                    cnt   <= '0;
                end
                ACCUM: begin
                    // Column 0 is final; shift it into the low product and renormalise S.
                    plo_q <= {row_s[0], plo_q[WIDTH-1:1]};
                    s_q   <= {1'b0, row_s[WIDTH-1:1]};
                    c_q   <= row_c;
                    b_r   <= b_r >> 1;
                    cnt   <= cnt + 1'b1;
                end
                RESOLVE: begin
                    if (c_q == '0) begin
                        product <= {s_q, plo_q};
                    end else begin
                        // Top carry-out is provably zero for an exact product.
                        s_q <= row_s;
                        c_q <= {row_c[WIDTH-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == ACCUM) || (state == RESOLVE);

endmodule

// File: tb/tb_csm_seq_mult_ctrl.sv
// Scoreboard bench for csm_seq_mult_ctrl: accepts push expected product and latency,
// output transfers pop and compare.
module tb_csm_seq_mult_ctrl;
    localparam int W = 25;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a = '0, b = '0;
    logic           in_ready, out_valid, busy;
    logic [2*W-1:0] product;

    typedef struct {
        logic [2*W-1:0] prod;
        int             t;
        int             k;
    } exp_t;

    exp_t           sb[$];
    int             tests = 0, fails = 0, cyc = 0;
    int             n_acc = 0, n_xfer = 0, ov_cnt = 0;
    bit             ordy_rand = 1'b0, rise_seen = 1'b0;
    logic [2*W-1:0] last_prod = '0;

    csm_seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        tests++;
        fails++;
        $display("FAIL %s", nm);
    endtask

    // Number of carry-propagation steps after the WIDTH accumulate steps.
    function automatic int model_k(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] s, c, pp, sn, cn;
        int k;
        s = '0; c = '0; k = 0;
        for (int i = 0; i < W; i++) begin
            pp = y[i] ? x : '0;
            sn = pp ^ s ^ c;
            cn = (pp & s) | (pp & c) | (s & c);
            s  = sn >> 1;
            c  = cn;
        end
        while (c != '0) begin
            sn = s ^ c;
            c  = (s & c) << 1;
            s  = sn;
            k++;
        end
        return k;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        logic [63:0] p;
        cyc++;
        if (!rst) begin
            if (out_valid) begin
                ov_cnt++;
                if (!rise_seen) begin
                    rise_seen = 1'b1;
                    if (sb.size() > 0) chk("latency", 64'(cyc - 1), 64'(sb[0].t + W + sb[0].k + 1));
                    else flag("out_valid_without_accept");
                end
                if (out_ready) begin
                    n_xfer++;
                    rise_seen = 1'b0;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("product", 64'(product), 64'(e.prod));
                        last_prod = product;
                    end else flag("unexpected_transfer");
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                p = 64'(a) * 64'(b);
                e.prod = p[2*W-1:0];
                e.t    = cyc;
                e.k    = model_k(a, b);
                sb.push_back(e);
            end
        end
    end

    always @(negedge clk) if (ordy_rand) out_ready = ($urandom_range(0, 3) != 0);

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; a = x; b = y;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) flag("issue_timeout");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 2000) begin @(negedge clk); n++; end
        if (sb.size() != 0 || !in_ready) flag("drain_timeout");
    endtask

    initial begin
        int n, ov_before;
        // Async reset visible before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Small operands, no carries left: out_valid 26 cycles after accept
        out_ready = 1'b1;
        issue(25'd3, 25'd5);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("lat_3x5", 64'(n), 64'd26);
        drain();
        chk("prod_3x5", 64'(last_prod), 64'd15);

        issue({W{1'b1}}, {W{1'b1}});
        drain();
        chk("prod_max", 64'(last_prod), 64'h3FFFFFC000001);

        issue(25'd0, {W{1'b1}});
        drain();
        chk("prod_zero", 64'(last_prod), 64'd0);

        // Back-pressure: product held, in_valid ignored
        out_ready = 1'b0;
        issue(25'd1000, 25'd1000);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin in_valid = 1'b1; a = 25'd5; b = 25'd5; end
            if (i == 6) in_valid = 1'b0;
            chk("bp_product", 64'(product), 64'd1000000);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("bp_xfer_count", 64'(n_xfer), 64'(n_acc));

        // Reset abort in cycle 12 of ACCUM
        issue(25'd123, 25'd456);
        repeat (11) @(negedge clk);
        chk("abort_busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_product", 64'(product), 64'd0);
        sb.delete();
        rise_seen = 1'b0;
        @(negedge clk); rst = 1'b0;
        ov_before = ov_cnt;
        repeat (60) @(negedge clk);
        chk("abort_no_out_valid", 64'(ov_cnt), 64'(ov_before));
        issue(25'd7, 25'd9);
        drain();
        chk("prod_7x9", 64'(last_prod), 64'd63);

        // Random regression with random output stalls
        n_acc = 0; n_xfer = 0;
        ordy_rand = 1'b1;
        for (int i = 0; i < 1500; i++) issue(W'($urandom), W'($urandom));
        drain();
        ordy_rand = 1'b0;
        chk("rand_xfer_count", 64'(n_xfer), 64'(n_acc));
        chk("rand_acc_count", 64'(n_acc), 64'd1500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
